// File: rtl/dab_param_scheduler_if.sv
// Host command channel of the dual-active-bridge parameter scheduler:
// a valid/ready handshake carrying t1, t2 and phi targets.
interface dab_param_scheduler_if;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [7:0]         cmd_t1;
    logic [7:0]         cmd_t2;
    logic signed [8:0]  cmd_phi;

    modport master (
        output cmd_valid,
        output cmd_t1,
        output cmd_t2,
        output cmd_phi,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_t1,
        input  cmd_t2,
        input  cmd_phi,
        output cmd_ready
    );
endinterface

// File: rtl/dab_param_scheduler.sv
// Run-time sequencer for the dual-active-bridge modulator.
// Takes t1/t2/phi targets from the host, starts the modulator with a sync
// pulse, slews applied values toward the targets on carrier-period ticks,
// ramps down on stop and forces zero drive on fault.
// Build option: DAB_SOFTSTART_EN -- when defined, each tick moves a value by at
// most STEP_MAX; when undefined, a tick loads the effective target directly.
module dab_param_scheduler #(
    parameter int STEP_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 fault,
    input  logic                 period_tick,
    dab_param_scheduler_if.slave cmd,
    output logic signed [8:0]    t1_out,
    output logic signed [8:0]    t2_out,
    output logic signed [8:0]    phi_out,
    output logic                 sync_out,
    output logic                 ce_out,
    output logic                 at_target,
    output logic                 err_range,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_STOP  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

`ifdef DAB_SOFTSTART_EN
    localparam bit SOFTSTART_C = 1'b1;
`else
    localparam bit SOFTSTART_C = 1'b0;
`endif

    // Without soft start the limit exceeds any possible diff (|diff| <= 510),
    // so every step lands exactly on the target.
    localparam int                STEP_L_C   = SOFTSTART_C ? STEP_MAX : 511;
    localparam logic signed [9:0] STEP_POS_C = 10'(STEP_L_C);
    localparam logic signed [9:0] STEP_NEG_C = 10'(-STEP_L_C);
    localparam logic signed [8:0] STEP9_C    = 9'(SOFTSTART_C ? STEP_MAX : 255);
    localparam logic signed [8:0] PHI_BAD_C  = 9'sh100;

    // One slew step of cur toward tgt; never overshoots the target.
    function automatic logic signed [8:0] step_f(input logic signed [8:0] cur,
                                                 input logic signed [8:0] tgt);
        logic signed [9:0] diff_v;
        diff_v = $signed({tgt[8], tgt}) - $signed({cur[8], cur});
        if (diff_v > STEP_POS_C) begin
            return cur + STEP9_C;
        end else if (diff_v < STEP_NEG_C) begin
            return cur - STEP9_C;
        end else begin
            return tgt;
        end
    endfunction

    state_t            state_r;
    logic signed [8:0] tgt_t1_r, tgt_t2_r, tgt_phi_r;
    logic signed [8:0] t1_r, t2_r, phi_r;
    logic              ready_r, sync_r, ce_r, at_r, err_r;

    logic              accept_s, bad_phi_s, all_zero_s, all_at_tgt_s;
    logic signed [8:0] eff_t1_s, eff_t2_s, eff_phi_s;
    logic signed [8:0] nxt_t1_s, nxt_t2_s, nxt_phi_s;

    // Handshake decode, effective targets (zero while stopping) and next steps.
    always_comb begin
        accept_s  = cmd.cmd_valid & ready_r;
        bad_phi_s = (cmd.cmd_phi == PHI_BAD_C);
        if (state_r == ST_STOP) begin
            eff_t1_s  = 9'sd0;
            eff_t2_s  = 9'sd0;
            eff_phi_s = 9'sd0;
        end else begin
            eff_t1_s  = tgt_t1_r;
            eff_t2_s  = tgt_t2_r;
            eff_phi_s = tgt_phi_r;
        end
        nxt_t1_s     = step_f(t1_r, eff_t1_s);
        nxt_t2_s     = step_f(t2_r, eff_t2_s);
        nxt_phi_s    = step_f(phi_r, eff_phi_s);
        all_zero_s   = (t1_r == 9'sd0) && (t2_r == 9'sd0) && (phi_r == 9'sd0);
        all_at_tgt_s = (t1_r == tgt_t1_r) && (t2_r == tgt_t2_r) && (phi_r == tgt_phi_r);
    end

    // Sequencer FSM with registered outputs; fault overrides every other event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            tgt_t1_r  <= 9'sd0;
            tgt_t2_r  <= 9'sd0;
            tgt_phi_r <= 9'sd0;
            t1_r      <= 9'sd0;
            t2_r      <= 9'sd0;
            phi_r     <= 9'sd0;
            ready_r   <= 1'b0;
            sync_r    <= 1'b0;
            ce_r      <= 1'b0;
            at_r      <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            ready_r <= (state_r == ST_IDLE) || (state_r == ST_RUN);
            err_r   <= accept_s & bad_phi_s;
            // Targets load on the accept edge; steps this edge still use the old ones.
            if (accept_s && !bad_phi_s) begin
                tgt_t1_r  <= $signed({1'b0, cmd.cmd_t1});
                tgt_t2_r  <= $signed({1'b0, cmd.cmd_t2});
                tgt_phi_r <= cmd.cmd_phi;
            end

            if (fault) begin
                state_r <= ST_FAULT;
                t1_r    <= 9'sd0;
                t2_r    <= 9'sd0;
                phi_r   <= 9'sd0;
                sync_r  <= 1'b0;
                ce_r    <= 1'b0;
                at_r    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        sync_r  <= en;
                        ce_r    <= en;
                        at_r    <= 1'b0;
                        state_r <= en ? ST_START : ST_IDLE;
                    end
                    ST_START: begin
                        sync_r  <= 1'b0;
                        ce_r    <= 1'b1;
                        at_r    <= 1'b0;
                        state_r <= ST_RUN;
                    end
                    ST_RUN: begin
                        sync_r <= 1'b0;
                        ce_r   <= 1'b1;
                        at_r   <= en & all_at_tgt_s;
                        if (period_tick) begin
                            t1_r  <= nxt_t1_s;
                            t2_r  <= nxt_t2_s;
                            phi_r <= nxt_phi_s;
                        end
                        state_r <= en ? ST_RUN : ST_STOP;
                    end
                    ST_STOP: begin
                        sync_r <= 1'b0;
                        at_r   <= 1'b0;
                        if (period_tick) begin
                            t1_r  <= nxt_t1_s;
                            t2_r  <= nxt_t2_s;
                            phi_r <= nxt_phi_s;
                        end
                        if (en) begin
                            state_r <= ST_RUN;
                            ce_r    <= 1'b1;
                        end else if (all_zero_s) begin
                            state_r <= ST_IDLE;
                            ce_r    <= 1'b0;
                        end else begin
                            state_r <= ST_STOP;
                            ce_r    <= 1'b1;
                        end
                    end
                    ST_FAULT: begin
                        t1_r    <= 9'sd0;
                        t2_r    <= 9'sd0;
                        phi_r   <= 9'sd0;
                        sync_r  <= 1'b0;
                        ce_r    <= 1'b0;
                        at_r    <= 1'b0;
                        state_r <= en ? ST_FAULT : ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        t1_r    <= 9'sd0;
                        t2_r    <= 9'sd0;
                        phi_r   <= 9'sd0;
                        sync_r  <= 1'b0;
                        ce_r    <= 1'b0;
                        at_r    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cmd.cmd_ready = ready_r;
    assign t1_out        = t1_r;
    assign t2_out        = t2_r;
    assign phi_out       = phi_r;
    assign sync_out      = sync_r;
    assign ce_out        = ce_r;
    assign at_target     = at_r;
    assign err_range     = err_r;
    assign state_o       = state_r;

endmodule

// File: tb/tb_dab_param_scheduler.sv
// Scoreboard bench for dab_param_scheduler: the driver predicts every cycle's
// outputs from a behavioural model and queues them; a monitor compares them
// against the DUT on the falling edge. Directed checks cover the ramp scenario.
module tb_dab_param_scheduler;
    localparam int STEP_MAX = 4;
`ifdef DAB_SOFTSTART_EN
    localparam int SLEW = STEP_MAX;
`else
    localparam int SLEW = 100000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic fault = 1'b0;
    logic period_tick = 1'b0;
    logic signed [8:0] t1_out, t2_out, phi_out;
    logic sync_out, ce_out, at_target, err_range;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    dab_param_scheduler_if cmd_if ();

    dab_param_scheduler #(.STEP_MAX(STEP_MAX)) dut (
        .clk(clk), .rst(rst), .en(en), .fault(fault), .period_tick(period_tick),
        .cmd(cmd_if.slave),
        .t1_out(t1_out), .t2_out(t2_out), .phi_out(phi_out),
        .sync_out(sync_out), .ce_out(ce_out), .at_target(at_target),
        .err_range(err_range), .state_o(state_o)
    );

    typedef struct packed {
        logic [2:0]        st;
        logic              rdy, sync, ce, at, err;
        logic signed [8:0] t1, t2, phi;
    } obs_t;

    obs_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: mode per spec numbering, targets and applied values as ints.
    int m_st = 0;
    int m_tg[3] = '{0, 0, 0};
    int m_ap[3] = '{0, 0, 0};
    bit m_rdy = 1'b0, m_sync = 1'b0, m_ce = 1'b0, m_at = 1'b0, m_err = 1'b0;

    function automatic int approach(input int cur, input int tgt);
        int d;
        d = tgt - cur;
        if (d > SLEW) d = SLEW;
        if (d < -SLEW) d = -SLEW;
        return cur + d;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit acc, bad, eq, zero;
        int nst;
        int nap[3];
        obs_t e;
        if (rst) begin
            m_st = 0; m_tg = '{0, 0, 0}; m_ap = '{0, 0, 0};
            m_rdy = 0; m_sync = 0; m_ce = 0; m_at = 0; m_err = 0;
        end else begin
            acc  = cmd_if.cmd_valid && m_rdy;
            bad  = acc && (int'(cmd_if.cmd_phi) == -256);
            eq   = (m_ap[0] == m_tg[0]) && (m_ap[1] == m_tg[1]) && (m_ap[2] == m_tg[2]);
            zero = (m_ap[0] == 0) && (m_ap[1] == 0) && (m_ap[2] == 0);
            nap  = m_ap;
            nst  = m_st;
            m_rdy = (m_st == 0) || (m_st == 2);
            if (fault) begin
                nst = 4; nap = '{0, 0, 0}; m_sync = 0; m_ce = 0; m_at = 0;
            end else if (m_st == 0) begin
                nst = en ? 1 : 0; m_sync = en; m_ce = en; m_at = 0;
            end else if (m_st == 1) begin
                nst = 2; m_sync = 0; m_ce = 1; m_at = 0;
            end else if (m_st == 2) begin
                if (period_tick) foreach (nap[i]) nap[i] = approach(m_ap[i], m_tg[i]);
                m_at = en && eq; m_sync = 0; m_ce = 1; nst = en ? 2 : 3;
            end else if (m_st == 3) begin
                if (period_tick) foreach (nap[i]) nap[i] = approach(m_ap[i], 0);
                m_at = 0; m_sync = 0;
                if (en) begin nst = 2; m_ce = 1; end
                else if (zero) begin nst = 0; m_ce = 0; end
                else m_ce = 1;
            end else begin
                nap = '{0, 0, 0}; m_sync = 0; m_ce = 0; m_at = 0; nst = en ? 4 : 0;
            end
            if (acc && !bad) begin
                m_tg[0] = int'(cmd_if.cmd_t1);
                m_tg[1] = int'(cmd_if.cmd_t2);
                m_tg[2] = int'(cmd_if.cmd_phi);
            end
            m_err = bad;
            m_st  = nst;
            m_ap  = nap;
        end
        e.st = 3'(m_st); e.rdy = m_rdy; e.sync = m_sync; e.ce = m_ce; e.at = m_at; e.err = m_err;
        e.t1 = 9'(m_ap[0]); e.t2 = 9'(m_ap[1]); e.phi = 9'(m_ap[2]);
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs, predict its edge, then wait until just after the edge.
    task automatic run(input bit r, input bit e, input bit f, input bit tk, input bit v,
                       input int t1, input int t2, input int phi);
        @(negedge clk);
        #1;
        rst = r; en = e; fault = f; period_tick = tk;
        cmd_if.cmd_valid = v;
        cmd_if.cmd_t1 = 8'(t1); cmd_if.cmd_t2 = 8'(t2); cmd_if.cmd_phi = 9'(phi);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic ramp_tick(input bit e);
        for (int j = 0; j < 3; j++) run(1'b0, e, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        run(1'b0, e, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: compare every DUT cycle against the queued prediction.
    initial begin
        obs_t e_v, a_v;
        int mcyc;
        mcyc = 0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (exp_q.size() > 0) begin
                e_v = exp_q.pop_front();
                a_v.st = state_o; a_v.rdy = cmd_if.cmd_ready; a_v.sync = sync_out;
                a_v.ce = ce_out; a_v.at = at_target; a_v.err = err_range;
                a_v.t1 = t1_out; a_v.t2 = t2_out; a_v.phi = phi_out;
                n_tests++;
                if (a_v !== e_v) begin
                    n_fail++;
                    $display("FAIL outputs cyc=%0d got st=%0d rdy=%0b sync=%0b ce=%0b at=%0b err=%0b t1=%0d t2=%0d phi=%0d exp st=%0d rdy=%0b sync=%0b ce=%0b at=%0b err=%0b t1=%0d t2=%0d phi=%0d",
                             mcyc, a_v.st, a_v.rdy, a_v.sync, a_v.ce, a_v.at, a_v.err,
                             $signed(a_v.t1), $signed(a_v.t2), $signed(a_v.phi),
                             e_v.st, e_v.rdy, e_v.sync, e_v.ce, e_v.at, e_v.err,
                             $signed(e_v.t1), $signed(e_v.t2), $signed(e_v.phi));
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized run.
    initial begin
        bit en_v;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_t1 = 8'd0; cmd_if.cmd_t2 = 8'd0; cmd_if.cmd_phi = 9'sd0;

        // Reset, then release.
        for (int i = 0; i < 3; i++) run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("reset_state", int'(state_o), 0);
        chk("reset_ready", int'(cmd_if.cmd_ready), 0);
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("ready_after_reset", int'(cmd_if.cmd_ready), 1);

        // Soft start toward t1=100, t2=60, phi=-17.
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 100, 60, -17);
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("sync_pulse", int'(sync_out), 1);
        chk("start_state", int'(state_o), 1);
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("sync_drop", int'(sync_out), 0);
        chk("run_state", int'(state_o), 2);
        for (int k = 1; k <= 26; k++) begin
            ramp_tick(1'b1);
            if (k <= 5) chk("phi_ramp", int'(phi_out), imax(-17, -SLEW * k));
            if (k == 15) chk("t2_tick15", int'(t2_out), 60);
            if (k == 24) chk("t1_tick24", int'(t1_out), imin(100, SLEW * 24));
            if (k == 25) chk("t1_tick25", int'(t1_out), 100);
        end
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("at_target", int'(at_target), 1);

        // Rejected phi=-256 in RUN.
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5, 5, -256);
        chk("err_pulse", int'(err_range), 1);
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("err_clear", int'(err_range), 0);
        ramp_tick(1'b1);
        chk("target_kept", int'(t1_out), 100);

        // Brief stop, resume, then command accepted on a tick edge.
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        run(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        chk("stop_step", int'(t1_out), imax(0, 100 - SLEW));
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        run(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 200, 60, -17);
        chk("tick_old_target", int'(t1_out), 100);
        ramp_tick(1'b1);
        chk("tick_new_target", int'(t1_out), imin(200, 100 + SLEW));

        // Fault mid-ramp; en=1 keeps FAULT, en=0 with fault clear exits.
        ramp_tick(1'b1);
        run(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        chk("fault_state", int'(state_o), 4);
        chk("fault_t1", int'(t1_out), 0);
        chk("fault_ce", int'(ce_out), 0);
        run(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        run(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("fault_hold", int'(state_o), 4);
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("fault_exit", int'(state_o), 0);

        // Full ramp up to 100, then stop down to IDLE.
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 100, 60, -17);
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        for (int k = 1; k <= 26; k++) ramp_tick(1'b1);
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        for (int k = 1; k <= 27; k++) begin
            ramp_tick(1'b0);
            chk("stop_ramp", int'(t1_out), imax(0, 100 - SLEW * k));
        end
        chk("stop_idle", int'(state_o), 0);
        chk("stop_ce", int'(ce_out), 0);

        // Reset mid-run.
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        ramp_tick(1'b1);
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("rst_run_state", int'(state_o), 0);
        chk("rst_run_t1", int'(t1_out), 0);
        chk("rst_run_ready", int'(cmd_if.cmd_ready), 0);

        // Randomized traffic.
        en_v = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bit r_v, f_v, tk_v, v_v;
            int p;
            if ($urandom_range(0, 39) == 0) en_v = !en_v;
            r_v  = ($urandom_range(0, 599) == 0);
            f_v  = ($urandom_range(0, 149) == 0);
            tk_v = ($urandom_range(0, 3) == 0);
            v_v  = ($urandom_range(0, 2) == 0);
            p    = int'($urandom_range(0, 510)) - 255;
            if ($urandom_range(0, 15) == 0) p = -256;
            run(r_v, en_v, f_v, tk_v, v_v, int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), p);
        end
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dab_param_scheduler.md
# dab_param_scheduler

Run-time sequencer for the dual-active-bridge modulator. Accepts duty/phase commands (t1, t2, phi) from the host over a valid/ready handshake and starts the modulator with a one-cycle sync pulse. Slews the applied values toward the commanded targets only at carrier-period boundaries and ramps them down on stop. Gates the modulator clock-enable and forces zero drive on fault.

## Interface

Parameters:
- STEP_MAX, 4: maximum change per period boundary, in t/phi units (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  level; 1 requests running, 0 requests ramp-down and stop.
- fault  in  1  level; external protection trip.
- period_tick  in  1  one-cycle pulse from the modulator at each carrier-period start.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command ready (registered).
- cmd_t1  in  8  primary pulse width target, 0..255.
- cmd_t2  in  8  secondary pulse width target, 0..255.
- cmd_phi  in  9 signed  phase target, legal range -255..255.
- t1_out  out  9 signed  applied t1 to modulator, 0..255.
- t2_out  out  9 signed  applied t2 to modulator, 0..255.
- phi_out  out  9 signed  applied phi to modulator.
- sync_out  out  1  one-cycle modulator start pulse.
- ce_out  out  1  modulator clock-enable.
- at_target  out  1  1 in RUN when all applied values equal targets.
- err_range  out  1  one-cycle pulse on rejected command.
- state_o  out  3  IDLE=0, START=1, RUN=2, STOP=3, FAULT=4.

## Operation

- Reset:
  - state IDLE.
  - Targets and all outputs 0.
  - cmd_ready 0, sync_out 0, ce_out 0, at_target 0, err_range 0.
- Handshake:
  - cmd_ready is 1 in IDLE and RUN and 0 otherwise. It is registered, so it follows the state with a one-cycle delay.
  - A command is accepted when cmd_valid & cmd_ready. Accepted values load the target registers on that edge.
  - cmd_phi = -256 is rejected: the command is consumed, the targets are unchanged, and err_range pulses for one cycle.
- FSM:
  - IDLE: on en=1 and fault=0, go to START.
  - START: lasts one cycle with sync_out=1 and ce_out=1, then goes to RUN.
  - RUN: ce_out=1. On each period_tick, each applied value steps toward its target.
  - RUN on en=0: go to STOP.
  - STOP: ce_out=1 and the effective targets are 0; the stored targets are retained.
    - On each period_tick, values step toward 0.
    - When all three applied values are 0, go to IDLE and drop ce_out.
    - en=1 in STOP returns to RUN with no sync pulse.
  - FAULT: entered from any state while fault=1, with priority over every other event.
    - Next edge: outputs forced 0, ce_out 0, sync_out 0.
    - Exit to IDLE only when fault=0 and en=0.
- Step arithmetic (per value, 10-bit signed diff = target - applied):
  - diff > STEP_MAX: add STEP_MAX.
  - diff < -STEP_MAX: subtract STEP_MAX.
  - Otherwise: load the target exactly.
  - No overshoot; results always stay within the legal range.
- Simultaneous events:
  - Command accept and period_tick in the same cycle: the step uses the old target; the new target takes effect from the next tick.
  - period_tick in IDLE, START or FAULT is ignored.

## Timing

- Applied outputs update on the clock edge that samples period_tick (one-cycle latency); they are constant between ticks.
- sync_out is asserted for exactly one cycle, the cycle after en is sampled high in IDLE.
- A target change of D reaches the output after ceil(|D|/STEP_MAX) ticks.
- at_target is registered and is valid the cycle after the final step.
- Fault response is one edge: synchronous sampling of fault, with no combinational path to the outputs.
- Reset mid-ramp: all outputs return to 0 asynchronously; in-flight commands are lost.

## Configuration

- DAB_SOFTSTART_EN defined: slew-limited stepping by STEP_MAX, in both RUN and STOP, as described above.
- DAB_SOFTSTART_EN undefined:
  - The first period_tick in RUN loads the targets directly.
  - STOP zeroes the outputs on the first tick and goes to IDLE on the following cycle.
  - STEP_MAX is unused.

## Test plan

- Reset:
  - Assert rst mid-RUN → outputs 0, state_o 0, cmd_ready 0.
  - Deassert rst → cmd_ready 1 one cycle later.
- Soft start with STEP_MAX=4:
  - Stimulus: command t1=100, t2=60, phi=-17 in IDLE, then en=1.
  - sync_out pulses once, then state_o becomes 2.
  - phi sequence: -4, -8, -12, -16, -17 over ticks 1..5.
  - t2 reaches 60 at tick 15.
  - t1 reaches 100 at tick 25; at_target rises one cycle later.
- Range error: command phi=-256 in RUN → err_range pulses 1 cycle and targets are unchanged.
- Same-cycle accept + tick: command t1=200 arrives with the tick at t1_out=96 (old target 100) → output 100 on that tick, 104 on the next.
- Fault mid-ramp:
  - fault=1 → next edge all outputs 0, ce_out 0, state_o 4; en=1 is ignored.
  - fault=0 and en=0 → state_o 0.
- Stop and compile-out:
  - en=0 at t1_out=100 → t1 steps down by 4 per tick; IDLE and ce_out=0 once all values reach 0.
  - With DAB_SOFTSTART_EN undefined: first tick gives t1_out=100 directly.
